// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain transmit driver.
package ccff_pkg;

    localparam int unsigned CCFF_DATA_W = 8;
    localparam int unsigned CCFF_CNT_W  = 16;

    // cby_2_1 tile: one 4-bit size8 mem plus nine 3-bit size6 mems.
    localparam int unsigned CBY_2_1_CHAIN_LEN = 4 + 9 * 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_FINISH
    } ccff_drv_state_e;

endpackage

// File: rtl/ccff_chain_driver_if.sv
// Word stream in from the bitstream source and readback words out.
interface ccff_chain_driver_if
    import ccff_pkg::*;
#(
    parameter int unsigned DATA_W = CCFF_DATA_W
) ();

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] rb_data;
    logic              rb_valid;

    modport master (
        output s_data, s_valid,
        input  s_ready, rb_data, rb_valid
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, rb_data, rb_valid
    );

endinterface

// File: rtl/ccff_rb_packer.sv
// Repacks bits leaving the chain tail into MSB-first words; a partial word
// is flushed left-aligned when the load finishes.
module ccff_rb_packer
    import ccff_pkg::*;
#(
    parameter int unsigned DATA_W = CCFF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sample_i,
    input  logic              tail_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] rb_data_o,
    output logic              rb_valid_o
);

    localparam int unsigned CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;

    // Accumulate one tail bit per enabled edge, emit on full word or flush.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        if (sample_i) begin
            acc_d = {acc_q[DATA_W-2:0], tail_i};
            cnt_d = cnt_q + 1'b1;
        end
        if ((cnt_d == CW'(DATA_W)) || (flush_i && (cnt_d != '0))) begin
            rb_data_d  = acc_d << (CW'(DATA_W) - cnt_d);
            rb_valid_d = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
        end else if (flush_i) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_data_o  = rb_data_q;
    assign rb_valid_o = rb_valid_q;

endmodule

// File: rtl/ccff_chain_driver.sv
// Serializes configuration words onto ccff_head with config_enable, and
// collects the bits returning on ccff_tail into readback words.
module ccff_chain_driver
    import ccff_pkg::*;
#(
    parameter int unsigned DATA_W = CCFF_DATA_W,
    parameter int unsigned CNT_W  = CCFF_CNT_W
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                start,
    input  logic [CNT_W-1:0]    chain_len,
    ccff_chain_driver_if.slave  bus,
    output logic                ccff_head,
    output logic                config_enable,
    input  logic                ccff_tail,
    output logic                busy,
    output logic                done
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    ccff_drv_state_e   state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              head_q, head_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              s_ready;

    // Next-state and registered-output logic; head/enable lag the state by
    // one cycle, so the FINISH cycle still carries the final shifted bit.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        bit_idx_d   = bit_idx_q;
        word_d      = word_q;
        head_d      = head_q;
        en_d        = 1'b0;
        done_d      = 1'b0;
        s_ready     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = chain_len;
                    state_d     = (chain_len == '0) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FETCH: begin
                s_ready = 1'b1;
                if (bus.s_valid) begin
                    word_d    = bus.s_data;
                    bit_idx_d = IDX_W'(DATA_W - 1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                head_d      = word_q[bit_idx_q];
                en_d        = 1'b1;
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == CNT_W'(1)) begin
                    state_d = ST_FINISH;
                end else if (bit_idx_q == '0) begin
                    state_d = ST_FETCH;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            bit_idx_q   <= '0;
            word_q      <= '0;
            head_q      <= 1'b0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bit_idx_q   <= bit_idx_d;
            word_q      <= word_d;
            head_q      <= head_d;
            en_q        <= en_d;
            done_q      <= done_d;
        end
    end

    assign bus.s_ready   = s_ready;
    assign ccff_head     = head_q;
    assign config_enable = en_q;
    assign done          = done_q;
    assign busy          = (state_q != ST_IDLE) || done_q;

    ccff_rb_packer #(
        .DATA_W (DATA_W)
    ) u_rb_packer (
        .clk_i      (prog_clk),
        .rst_ni     (pReset),
        .sample_i   (en_q),
        .tail_i     (ccff_tail),
        .flush_i    (state_q == ST_FINISH),
        .rb_data_o  (bus.rb_data),
        .rb_valid_o (bus.rb_valid)
    );

endmodule

// File: tb/tb_ccff_chain_driver.sv
// Directed bench for ccff_chain_driver against a 31-bit chain model.
module tb_ccff_chain_driver;
    import ccff_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 16;
    localparam int unsigned CHAIN = CBY_2_1_CHAIN_LEN;

    // 0xA5 3C F0 0E with the LSB of the last word dropped
    localparam logic [31:0] EXP_CHAIN = 32'h529E_7807;

    logic          prog_clk = 1'b0;
    logic          pReset   = 1'b0;
    logic          start    = 1'b0;
    logic [CW-1:0] chain_len = '0;
    logic          ccff_head, config_enable, ccff_tail, busy, done;

    ccff_chain_driver_if #(.DATA_W(DW)) bus ();

    ccff_chain_driver #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .chain_len     (chain_len),
        .bus           (bus),
        .ccff_head     (ccff_head),
        .config_enable (config_enable),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done)
    );

    always #5 prog_clk = ~prog_clk;

    // chain of *_mem flops; first bit shifted in ends at the tail
    logic [CHAIN-1:0] chain;
    logic             preload = 1'b0;
    logic [CHAIN-1:0] preload_val = '0;
    assign ccff_tail = chain[CHAIN-1];

    always @(posedge prog_clk) begin
        if (preload) chain <= preload_val;
        else if (config_enable) chain <= {chain[CHAIN-2:0], ccff_head};
    end

    // observation counters, sampled on the falling edge
    int          n_en = 0, n_done = 0, n_rb = 0, n_srdy = 0;
    logic [31:0] head_log = '0;
    logic [31:0] rb_hist  = '0;
    logic        rb_last_done = 1'b0;

    always @(negedge prog_clk) begin
        if (config_enable) begin
            n_en     <= n_en + 1;
            head_log <= {head_log[30:0], ccff_head};
        end
        if (done) n_done <= n_done + 1;
        if (bus.s_ready) n_srdy <= n_srdy + 1;
        if (bus.rb_valid) begin
            n_rb         <= n_rb + 1;
            rb_hist      <= {rb_hist[23:0], bus.rb_data};
            rb_last_done <= done;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int stall_en = 0;
    logic [DW-1:0] words [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_chain(input logic [CHAIN-1:0] v);
        preload_val = v;
        preload     = 1'b1;
        @(posedge prog_clk); #1;
        preload     = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int unsigned stall);
        int unsigned t;
        t = 0;
        while (!bus.s_ready && t < 50) begin
            @(negedge prog_clk);
            t++;
        end
        chk("s_ready_wait", 32'(bus.s_ready), 32'd1);
        for (int unsigned k = 0; k < stall; k++) begin
            @(negedge prog_clk);
            if (config_enable) stall_en++;
        end
        bus.s_data  = w;
        bus.s_valid = 1'b1;
        @(posedge prog_clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic do_load(input logic [CW-1:0] len, input int unsigned stall_idx,
                           input int unsigned stall_n, input bit poke);
        int unsigned nw, t;
        int          db;
        nw = (32'(len) + DW - 1) / DW;
        db = n_done;
        start     = 1'b1;
        chain_len = len;
        @(posedge prog_clk); #1;
        start     = 1'b0;
        for (int unsigned i = 0; i < nw; i++) begin
            send_word(words[i % 4], (i == stall_idx) ? stall_n : 0);
            if (poke && i == 1) begin
                start     = 1'b1;
                chain_len = 16'd5;
                @(posedge prog_clk); #1;
                start     = 1'b0;
                chain_len = len;
            end
        end
        t = 0;
        while (n_done == db && t < 100) begin
            @(negedge prog_clk);
            t++;
        end
        repeat (3) @(negedge prog_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, d0, rb0, sr0, t;
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'hF0;
        words[3] = 8'h0E;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;

        // reset state
        #12;
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_head",    32'(ccff_head), 32'd0);
        chk("rst_enable",  32'(config_enable), 32'd0);
        chk("rst_rb_data", 32'(bus.rb_data), 32'd0);
        chk("rst_rb_valid", 32'(bus.rb_valid), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_done",    32'(done), 32'd0);
        #10 pReset = 1'b1;
        @(posedge prog_clk); #1;

        // basic load, chain preloaded with zeros
        load_chain('0);
        en0 = n_en; d0 = n_done; rb0 = n_rb;
        do_load(16'(CHAIN), 99, 0, 1'b0);
        chk("basic_en_cycles", 32'(n_en - en0), 32'd31);
        chk("basic_done",      32'(n_done - d0), 32'd1);
        chk("basic_head_seq",  head_log & 32'h7FFF_FFFF, EXP_CHAIN);
        chk("basic_chain",     32'(chain), EXP_CHAIN);
        chk("basic_rb_count",  32'(n_rb - rb0), 32'd4);
        chk("basic_rb_words",  rb_hist, 32'h0000_0000);
        chk("basic_busy_end",  32'(busy), 32'd0);

        // readback with chain preloaded to all ones
        load_chain('1);
        en0 = n_en; d0 = n_done; rb0 = n_rb;
        do_load(16'(CHAIN), 99, 0, 1'b0);
        chk("rb_count",     32'(n_rb - rb0), 32'd4);
        chk("rb_words",     rb_hist, 32'hFFFF_FFFE);
        chk("rb_last_done", 32'(rb_last_done), 32'd1);
        chk("rb_chain",     32'(chain), EXP_CHAIN);

        // stall of 5 cycles before the second word
        load_chain('0);
        en0 = n_en; d0 = n_done;
        stall_en = 0;
        do_load(16'(CHAIN), 1, 5, 1'b0);
        chk("stall_enable",   32'(stall_en), 32'd0);
        chk("stall_en_cycles", 32'(n_en - en0), 32'd31);
        chk("stall_head_seq", head_log & 32'h7FFF_FFFF, EXP_CHAIN);
        chk("stall_chain",    32'(chain), EXP_CHAIN);
        chk("stall_done",     32'(n_done - d0), 32'd1);

        // zero length
        en0 = n_en; d0 = n_done; rb0 = n_rb; sr0 = n_srdy;
        start     = 1'b1;
        chain_len = '0;
        @(posedge prog_clk); #1;
        start     = 1'b0;
        @(negedge prog_clk);
        chk("zl_done_c1", 32'(done), 32'd0);
        chk("zl_busy_c1", 32'(busy), 32'd1);
        @(negedge prog_clk);
        chk("zl_done_c2", 32'(done), 32'd1);
        chk("zl_busy_c2", 32'(busy), 32'd1);
        repeat (4) @(negedge prog_clk);
        chk("zl_s_ready", 32'(n_srdy - sr0), 32'd0);
        chk("zl_enable",  32'(n_en - en0), 32'd0);
        chk("zl_rb",      32'(n_rb - rb0), 32'd0);
        chk("zl_done_n",  32'(n_done - d0), 32'd1);
        chk("zl_busy_end", 32'(busy), 32'd0);

        // start pulse while shifting is ignored
        @(posedge prog_clk); #1;
        load_chain('0);
        en0 = n_en; d0 = n_done;
        do_load(16'(CHAIN), 99, 0, 1'b1);
        chk("poke_en_cycles", 32'(n_en - en0), 32'd31);
        chk("poke_done",      32'(n_done - d0), 32'd1);
        chk("poke_chain",     32'(chain), EXP_CHAIN);

        // reset in the middle of a load
        en0 = n_en;
        start     = 1'b1;
        chain_len = 16'(CHAIN);
        @(posedge prog_clk); #1;
        start     = 1'b0;
        send_word(words[0], 0);
        send_word(words[1], 0);
        t = 0;
        while ((n_en - en0) < 12 && t < 100) begin
            @(negedge prog_clk);
            t++;
        end
        chk("mid_reached", 32'((n_en - en0) >= 12), 32'd1);
        d0 = n_done; rb0 = n_rb;
        #2 pReset = 1'b0;
        #1;
        chk("mid_rst_head",    32'(ccff_head), 32'd0);
        chk("mid_rst_enable",  32'(config_enable), 32'd0);
        chk("mid_rst_busy",    32'(busy), 32'd0);
        chk("mid_rst_done",    32'(done), 32'd0);
        chk("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("mid_rst_rb_data", 32'(bus.rb_data), 32'd0);
        chk("mid_rst_rb_valid", 32'(bus.rb_valid), 32'd0);
        repeat (3) @(negedge prog_clk);
        pReset = 1'b1;
        repeat (3) @(negedge prog_clk);
        chk("mid_no_done", 32'(n_done - d0), 32'd0);
        chk("mid_no_rb",   32'(n_rb - rb0), 32'd0);
        chk("mid_idle",    32'(busy), 32'd0);

        @(posedge prog_clk); #1;
        en0 = n_en; d0 = n_done;
        do_load(16'(CHAIN), 99, 0, 1'b0);
        chk("reload_en_cycles", 32'(n_en - en0), 32'd31);
        chk("reload_done",      32'(n_done - d0), 32'd1);
        chk("reload_chain",     32'(chain), EXP_CHAIN);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ccff_chain_driver.md
Name: ccff_chain_driver

Overview:
- Transmit end of the configuration-chain protocol: serializes configuration words onto `ccff_head` and drives `config_enable` for a chain of `*_mem` flip-flops.
- Also captures the bits leaving the chain on `ccff_tail` and repacks them into words for readback/integrity checking.
- Sits between the bitstream source (decrypt/verify path) and the fabric's first `ccff_head`.

Parameters:
- DATA_W, 8, width of input and readback words (bits).
- CNT_W, 16, width of the bit counter and of `chain_len`.

Ports:
- prog_clk  input  1  configuration clock; all state on rising edge.
- pReset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- chain_len  input  CNT_W  number of bits to shift; latched on accepted `start`.
- s_data  input  DATA_W  configuration word, MSB shifted first.
- s_valid  input  1  `s_data` valid.
- s_ready  output  1  word accepted when `s_valid && s_ready`.
- ccff_head  output  1  serial bit to the chain head (registered).
- config_enable  output  1  chain shift enable (registered).
- ccff_tail  input  1  serial bit returning from the chain tail.
- rb_data  output  DATA_W  captured tail word, first-captured bit in MSB.
- rb_valid  output  1  one-cycle pulse, `rb_data` valid; no backpressure.
- busy  output  1  high from accepted `start` until the `done` cycle inclusive.
- done  output  1  one-cycle pulse at end of load.

Behaviour:
- Reset, async on `pReset`=0: FSM=IDLE; counters cleared; shift/readback registers cleared.
  - Outputs after reset: `s_ready`=0, `ccff_head`=0, `config_enable`=0, `rb_data`=0, `rb_valid`=0, `busy`=0, `done`=0.
  - Reset mid-load abandons the load immediately; no `done` pulse.
- FSM states: IDLE, FETCH, SHIFT, FINISH.
- IDLE:
  - `start`=1 latches `chain_len` into `remaining`.
  - If `chain_len`==0, go to FINISH; else go to FETCH.
  - `start` in any other state is ignored.
- FETCH:
  - `s_ready`=1 and `config_enable`=0.
  - On handshake, load the word into the shift register, set `bit_idx`=DATA_W-1, go to SHIFT.
  - If `s_valid`=0, wait indefinitely; the chain holds because `config_enable`=0.
- SHIFT: each cycle, registered `ccff_head`=`word[bit_idx]` and `config_enable`=1. The chain samples the bit at the following edge, so every cycle with `config_enable`=1 is exactly one shifted bit.
  - `remaining` decrements once per asserted-enable cycle.
  - When `remaining` reaches 0, go to FINISH. Unused low bits of the last word are discarded.
  - When `bit_idx` reaches 0 with `remaining`>0, go to FETCH. Default is a one-cycle bubble with `config_enable`=0.
  - Optional no-bubble path: may accept the next word in the last-bit cycle with `s_ready`=1. This is functionally equivalent for the chain, because bubbles never corrupt it.
- FINISH:
  - `config_enable`=0, `done`=1 for one cycle, `busy`=1 this cycle.
  - Flush any partial readback word (see below).
  - Next cycle go to IDLE.
- Readback:
  - Sample `ccff_tail` on every edge where registered `config_enable`=1, shifting into a DATA_W accumulator MSB-first.
  - After DATA_W samples, `rb_data` = accumulator and `rb_valid` pulses.
  - If a partial word remains at FINISH, pulse `rb_valid` in the `done` cycle with captured bits left-aligned and low bits zero.
  - Total readback bits always equal `chain_len`.
- Width rules:
  - `remaining` is CNT_W bits and never wraps.
  - `chain_len` of all ones is legal: 65535 bits for CNT_W=16.

Decomposition:
- Shared package `ccff_pkg`:
  - FSM state enum `ccff_drv_state_e`.
  - Default DATA_W/CNT_W constants.
  - Chain-length constants per tile type, e.g. CBY_2_1_CHAIN_LEN=31 (one 4-bit size8 mem plus nine 3-bit size6 mems).
- One natural sub-module: `ccff_rb_packer`, the tail sampling, bit counter and partial-word flush.

Test Plan:
- Basic load, `chain_len`=31, words 0xA5, 0x3C, 0xF0, 0x0E, 31-bit chain model preloaded with 0s:
  - `ccff_head` sequence is 10100101 00111100 11110000 0000111. The LSB of 0x0E is dropped.
  - Exactly 31 `config_enable` cycles, then `done` pulses once.
  - Chain model holds that bit pattern.
- Readback, same load with chain preloaded 0x7FFFFFFF (first-out bit 1):
  - `rb_valid` ×4 with `rb_data` 0xFF, 0xFF, 0xFF, 0xFE. The last word is 7 bits left-aligned, coincident with `done`.
- Stall: hold `s_valid`=0 for 5 cycles before word 2:
  - `config_enable`=0 throughout the stall.
  - Final chain contents and `ccff_head` bit order are identical to the basic load.
- Zero length, `start` with `chain_len`=0:
  - No `s_ready`, no `config_enable`, no `rb_valid`.
  - `done`=1 two cycles after `start`.
- Start while busy: `start` pulses during SHIFT are ignored; the shift count stays 31.
- Reset mid-load: assert `pReset`=0 after 12 shifted bits.
  - All outputs 0 asynchronously; no `done` pulse.
  - A new load of 31 bits completes normally.
